// File: rtl/rx_module.sv
// 8N1 UART receiver: synchronized input, mid-bit sampling, one-cycle done/frame-error pulses.
// Leaves IDLE on a falling edge only, and returns right after the stop sample so back-to-back frames are caught.
module rx_module #(
  parameter int BPS_CNT = 434
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       Rx_Pin_In,
  input  logic       Rx_En_Sig,
  output logic [7:0] Rx_Data,
  output logic       Rx_Done_Sig,
  output logic       Frame_Err
);

  localparam logic [15:0] WRAP_PT   = 16'(BPS_CNT - 1);
  localparam logic [15:0] SAMPLE_PT = 16'(BPS_CNT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, hist_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        wrap, sample;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= Rx_Pin_In;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign wrap   = (cnt_q == WRAP_PT);
  assign sample = (cnt_q == SAMPLE_PT);

  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (Rx_En_Sig && hist_q && !sync2_q) state_d = START;
      end
      START: begin
        if (!Rx_En_Sig) begin
          state_d = IDLE;
        end else if (sample && sync2_q) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (!Rx_En_Sig) begin
          state_d = IDLE;
        end else begin
          if (sample) shift_d = {sync2_q, shift_q[7:1]};
          if (wrap) begin
            if (idx_q == 3'd7) state_d = STOP;
            else               idx_d   = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (!Rx_En_Sig) begin
          state_d = IDLE;
        end else if (sample) begin
          // Leave at the stop sample so a start edge half a bit later is not missed.
          state_d = IDLE;
          if (sync2_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Rx_Data     = data_q;
  assign Rx_Done_Sig = done_q;
  assign Frame_Err   = ferr_q;

endmodule
